axi_r_burst_buffer: RTL and testbench



---
 rtl/axi_r_burst_buffer_pkg.sv | 23 ++
 rtl/axi_channel_fifo.sv | 61 ++++++
 rtl/axi_r_burst_buffer_chk.sv | 23 ++
 rtl/axi_r_burst_buffer.sv | 116 +++++++++++
 tb/tb_axi_r_burst_buffer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_r_burst_buffer_pkg.sv
// Shared types and helpers for the R-channel burst buffer and its storage FIFO.
// Buffer mode selects cut-through or store-and-forward release of beats.
package axi_r_burst_buffer_pkg;

  typedef enum logic [0:0] {
    AXI_RB_CUT = 1'b0,
    AXI_RB_SAF = 1'b1
  } buf_mode_e;

  // Up/down counter step; simultaneous inc and dec cancel out.
  function automatic logic [31:0] cnt_step(input logic [31:0] cnt,
                                           input logic        inc,
                                           input logic        dec);
    logic [31:0] res;
    case ({inc, dec})
      2'b10:   res = cnt + 32'd1;
      2'b01:   res = cnt - 32'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi_channel_fifo.sv
// Generic payload FIFO for one AXI channel: storage, wrapping pointers, occupancy.
// Input ready is registered so it never depends combinationally on the pop side.
module axi_channel_fifo
  import axi_r_burst_buffer_pkg::*;
#(
  parameter int PAYLD_WIDTH = 42,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [PAYLD_WIDTH-1:0] wr_data,
  output logic [PAYLD_WIDTH-1:0] rd_data,
  output logic                   in_ready,
  output logic                   empty,
  output logic [CNT_WIDTH-1:0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [PAYLD_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CNT_WIDTH-1:0]   occ_r;
  logic [CNT_WIDTH-1:0]   occ_nxt_s;
  logic                   ready_r;

  // Next occupancy drives both the counter and the registered ready.
  always_comb begin
    occ_nxt_s = CNT_WIDTH'(cnt_step(32'(occ_r), push, pop));
  end

  // Pointers, occupancy and ready; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      ready_r  <= 1'b0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      occ_r   <= occ_nxt_s;
      ready_r <= (occ_nxt_s != FULL_CNT);
    end
  end

  // Payload storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data   = mem_r[rd_ptr_r];
  assign in_ready  = ready_r;
  assign empty     = (occ_r == '0);
  assign occupancy = occ_r;

endmodule

// File: rtl/axi_r_burst_buffer_chk.sv
// Invariant checker for the R-channel burst buffer counters and s-side stability.
module axi_r_burst_buffer_chk #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic [CNT_WIDTH-1:0] occupancy,
  input logic [CNT_WIDTH-1:0] bursts_held,
  input logic                 rvalids,
  input logic                 rreadys
);

  a_bursts_le_occ: assert property (@(posedge clk) disable iff (rst)
    bursts_held <= occupancy);

  a_occ_le_depth: assert property (@(posedge clk) disable iff (rst)
    occupancy <= CNT_WIDTH'(DEPTH));

  a_rvalid_hold: assert property (@(posedge clk) disable iff (rst)
    (rvalids && !rreadys) |=> rvalids);

endmodule

// File: rtl/axi_r_burst_buffer.sv
// Multi-entry AXI/ACE read-data buffer with optional store-and-forward release.
// Adds burst counting and the SAF gating/sticky-release on top of the channel FIFO.
module axi_r_burst_buffer
  import axi_r_burst_buffer_pkg::*;
#(
  parameter int        DATA_WIDTH = 32,
  parameter int        ID_WIDTH   = 4,
  parameter int        USER_WIDTH = 1,
  parameter int        RESP_WIDTH = 4,
  parameter int        DEPTH      = 4,
  parameter buf_mode_e BUF_MODE   = AXI_RB_CUT,
  parameter int        CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  rvalidm,
  output logic                  rreadym,
  input  logic [ID_WIDTH-1:0]   ridm,
  input  logic [DATA_WIDTH-1:0] rdatam,
  input  logic [RESP_WIDTH-1:0] rrespm,
  input  logic                  rlastm,
  input  logic [USER_WIDTH-1:0] ruserm,
  output logic                  rvalids,
  input  logic                  rreadys,
  output logic [ID_WIDTH-1:0]   rids,
  output logic [DATA_WIDTH-1:0] rdatas,
  output logic [RESP_WIDTH-1:0] rresps,
  output logic                  rlasts,
  output logic [USER_WIDTH-1:0] rusers,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]  bursts_held
);

  localparam int PAYLD_WIDTH = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + USER_WIDTH + 1;

  logic                   push_s;
  logic                   pop_s;
  logic                   empty_s;
  logic                   release_s;
  logic                   sticky_r;
  logic                   sticky_nxt_s;
  logic [CNT_WIDTH-1:0]   bursts_r;
  logic [PAYLD_WIDTH-1:0] wr_payld_s;
  logic [PAYLD_WIDTH-1:0] rd_payld_s;

  assign push_s     = rvalidm & rreadym;
  assign pop_s      = rvalids & rreadys;
  assign wr_payld_s = {ridm, rdatam, rrespm, rlastm, ruserm};
  assign {rids, rdatas, rresps, rlasts, rusers} = rd_payld_s;

  axi_channel_fifo #(
    .PAYLD_WIDTH (PAYLD_WIDTH),
    .DEPTH       (DEPTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (push_s),
    .pop       (pop_s),
    .wr_data   (wr_payld_s),
    .rd_data   (rd_payld_s),
    .in_ready  (rreadym),
    .empty     (empty_s),
    .occupancy (occupancy)
  );

  // A full buffer with no complete burst must drain anyway to avoid deadlock.
  assign release_s = (occupancy == CNT_WIDTH'(DEPTH));

  // Popping a non-last beat with no complete burst held means release started
  // this burst; keep it flowing until its last beat leaves.
  always_comb begin
    if (pop_s && rlasts) begin
      sticky_nxt_s = 1'b0;
    end else if (pop_s && (bursts_r == '0)) begin
      sticky_nxt_s = 1'b1;
    end else begin
      sticky_nxt_s = sticky_r;
    end
  end

  // Complete-burst counter and sticky release flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bursts_r <= '0;
      sticky_r <= 1'b0;
    end else begin
      bursts_r <= CNT_WIDTH'(cnt_step(32'(bursts_r), push_s & rlastm, pop_s & rlasts));
      sticky_r <= sticky_nxt_s;
    end
  end

  // S-side valid, decoded only from registered state.
  always_comb begin
    if (BUF_MODE == AXI_RB_SAF) begin
      rvalids = !empty_s && ((bursts_r != '0) || release_s || sticky_r);
    end else begin
      rvalids = !empty_s;
    end
  end

  assign bursts_held = bursts_r;

  axi_r_burst_buffer_chk #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_chk (
    .clk         (aclk),
    .rst         (areset),
    .occupancy   (occupancy),
    .bursts_held (bursts_r),
    .rvalids     (rvalids),
    .rreadys     (rreadys)
  );

endmodule

// File: tb/tb_axi_r_burst_buffer.sv
// Self-checking bench: three buffers (CUT/4, SAF/8, SAF/4) against a queue-based
// reference model, plus a vector table and directed corner-case sequences.
module tb_axi_r_burst_buffer;
  import axi_r_burst_buffer_pkg::*;

  localparam int NI = 3;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  resp;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic        vm;
    logic [31:0] d;
    logic        last;
    logic        rs;
    logic        e_rdy;
    logic        e_vld;
    int          e_occ;
    logic [31:0] e_d;
  } vec_t;

  logic  aclk   = 1'b0;
  logic  areset = 1'b1;
  logic  vm [NI];
  logic  rs [NI];
  beat_t bin [NI];

  wire        rdym_w  [NI];
  wire        vs_w    [NI];
  wire [3:0]  ids_w   [NI];
  wire [31:0] datas_w [NI];
  wire [3:0]  resps_w [NI];
  wire        lasts_w [NI];
  wire        users_w [NI];
  wire [3:0]  occ_w   [NI];
  wire [3:0]  bh_w    [NI];

  beat_t mq     [NI][$];
  beat_t popped [NI][$];
  logic  msticky [NI];
  logic  mrdy    [NI];
  logic  push_e  [NI];
  logic  pop_e   [NI];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   b_idx;
  vec_t tbl [12];

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axi_r_burst_buffer #(
      .DATA_WIDTH (32),
      .ID_WIDTH   (4),
      .USER_WIDTH (1),
      .RESP_WIDTH (4),
      .DEPTH      ((g == 1) ? 8 : 4),
      .BUF_MODE   ((g == 0) ? AXI_RB_CUT : AXI_RB_SAF),
      .CNT_WIDTH  (4)
    ) u_dut (
      .aclk        (aclk),
      .areset      (areset),
      .rvalidm     (vm[g]),
      .rreadym     (rdym_w[g]),
      .ridm        (bin[g].id),
      .rdatam      (bin[g].data),
      .rrespm      (bin[g].resp),
      .rlastm      (bin[g].last),
      .ruserm      (bin[g].user),
      .rvalids     (vs_w[g]),
      .rreadys     (rs[g]),
      .rids        (ids_w[g]),
      .rdatas      (datas_w[g]),
      .rresps      (resps_w[g]),
      .rlasts      (lasts_w[g]),
      .rusers      (users_w[g]),
      .occupancy   (occ_w[g]),
      .bursts_held (bh_w[g])
    );
  end

  function automatic int dep(int i);
    return (i == 1) ? 8 : 4;
  endfunction

  function automatic int nlast(int i);
    int n = 0;
    for (int k = 0; k < mq[i].size(); k++) if (mq[i][k].last) n++;
    return n;
  endfunction

  // Valid from the rules: CUT shows any beat; SAF needs a whole burst, a full
  // buffer, or a burst already being released.
  function automatic logic mvalid(int i);
    if (mq[i].size() == 0) return 1'b0;
    if (i == 0) return 1'b1;
    return (nlast(i) > 0) || (mq[i].size() == dep(i)) || msticky[i];
  endfunction

  task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic sample();
    logic v;
    @(negedge aclk);
    for (int i = 0; i < NI; i++) begin
      v = mvalid(i);
      chk("rreadym", i, 64'(rdym_w[i]), 64'(mrdy[i]));
      chk("rvalids", i, 64'(vs_w[i]), 64'(v));
      chk("occupancy", i, 64'(occ_w[i]), 64'(mq[i].size()));
      chk("bursts_held", i, 64'(bh_w[i]), 64'(nlast(i)));
      if (v) chk("payload", i, 64'({ids_w[i], datas_w[i], resps_w[i], lasts_w[i], users_w[i]}),
                 64'(mq[i][0]));
      push_e[i] = vm[i] && mrdy[i];
      pop_e[i]  = v && rs[i];
    end
  endtask

  task automatic advance();
    @(posedge aclk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (areset) begin
        mq[i].delete();
        msticky[i] = 1'b0;
        mrdy[i]    = 1'b0;
      end else begin
        if (pop_e[i]) begin
          if (mq[i][0].last) msticky[i] = 1'b0;
          else if (nlast(i) == 0) msticky[i] = 1'b1;
          popped[i].push_back(mq[i][0]);
          void'(mq[i].pop_front());
        end
        if (push_e[i]) mq[i].push_back(bin[i]);
        mrdy[i] = (mq[i].size() != dep(i));
      end
    end
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic set_idle();
    for (int i = 0; i < NI; i++) begin
      vm[i]  = 1'b0;
      rs[i]  = 1'b0;
      bin[i] = '0;
    end
  endtask

  task automatic put(int i, logic v, logic [31:0] d, logic l, logic r);
    vm[i]       = v;
    bin[i]      = '0;
    bin[i].data = d;
    bin[i].last = l;
    bin[i].id   = d[3:0];
    rs[i]       = r;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'd0};
    tbl[1]  = '{1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'd0};
    tbl[2]  = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2, 32'd0};
    tbl[3]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3, 32'd0};
    tbl[4]  = '{1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4, 32'd0};
    tbl[5]  = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b0, 1'b1, 4, 32'd0};
    tbl[6]  = '{1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'd1};
    tbl[7]  = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 32'd1};
    tbl[8]  = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 32'd2};
    tbl[9]  = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 32'd3};
    tbl[10] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 32'd4};
    tbl[11] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'd0};

    for (int i = 0; i < NI; i++) begin
      msticky[i] = 1'b0;
      mrdy[i]    = 1'b0;
      push_e[i]  = 1'b0;
      pop_e[i]   = 1'b0;
    end
    set_idle();
    tick();
    tick();
    areset = 1'b0;
    tick();

    // CUT fill/full/drain vector table
    for (int k = 0; k < 12; k++) begin
      put(0, tbl[k].vm, tbl[k].d, tbl[k].last, tbl[k].rs);
      sample();
      chk("tbl_rreadym", k, 64'(rdym_w[0]), 64'(tbl[k].e_rdy));
      chk("tbl_rvalids", k, 64'(vs_w[0]), 64'(tbl[k].e_vld));
      chk("tbl_occ", k, 64'(occ_w[0]), 64'(tbl[k].e_occ));
      if (tbl[k].e_vld) chk("tbl_data", k, 64'(datas_w[0]), 64'(tbl[k].e_d));
      advance();
    end

    // CUT streaming burst 0..7, visible one cycle after each push
    for (int k = 0; k < 9; k++) begin
      put(0, k < 8, 32'(k), k == 7, 1'b1);
      sample();
      if (k == 0) chk("cut_first", k, 64'(vs_w[0]), 64'd0);
      else begin
        chk("cut_data", k, 64'(datas_w[0]), 64'(k - 1));
        chk("cut_last", k, 64'(lasts_w[0]), 64'(k == 8));
      end
      advance();
    end
    set_idle();
    tick();

    // SAF depth 8: gapped 3-beat burst held until its last beat lands
    for (int k = 0; k < 11; k++) begin
      put(1, (k == 0) || (k == 3) || (k == 6), 32'(100 + k), k == 6, 1'b1);
      sample();
      chk("saf_gate", k, 64'(vs_w[1]), 64'((k >= 7) && (k <= 9)));
      if (k == 7)  chk("saf_bursts1", k, 64'(bh_w[1]), 64'd1);
      if (k == 10) chk("saf_bursts0", k, 64'(bh_w[1]), 64'd0);
      advance();
    end
    set_idle();

    // SAF depth 4: 6-beat burst forces release and must not deadlock
    popped[2].delete();
    b_idx = 0;
    for (int k = 0; k < 12; k++) begin
      put(2, b_idx < 6, 32'(b_idx), b_idx == 5, 1'b1);
      sample();
      chk("saf_release", k, 64'(vs_w[2]), 64'((k >= 4) && (k <= 9)));
      advance();
      if (push_e[2]) b_idx++;
    end
    chk("saf_count", 2, 64'(popped[2].size()), 64'd6);
    for (int k = 0; k < popped[2].size(); k++)
      chk("saf_order", k, 64'(popped[2][k].data), 64'(k));
    set_idle();

    // Simultaneous last push and last pop at occupancy 2
    put(0, 1'b1, 32'd10, 1'b1, 1'b0); tick();
    put(0, 1'b1, 32'd11, 1'b1, 1'b0); tick();
    put(0, 1'b1, 32'd12, 1'b1, 1'b1); tick();
    put(0, 1'b0, 32'd0, 1'b0, 1'b0);
    sample();
    chk("simul_occ", 0, 64'(occ_w[0]), 64'd2);
    chk("simul_bursts", 0, 64'(bh_w[0]), 64'd2);
    advance();

    // Asynchronous reset mid-burst with occupancy 3 (instance 0 topped up)
    put(0, 1'b1, 32'd20, 1'b0, 1'b0); tick();
    put(0, 1'b0, 32'd0, 1'b0, 1'b0);
    put(2, 1'b1, 32'd30, 1'b0, 1'b0); tick(); tick(); tick();
    set_idle();
    sample();
    chk("pre_reset_occ", 2, 64'(occ_w[2]), 64'd3);
    advance();
    #1 areset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("arst_rvalids", i, 64'(vs_w[i]), 64'd0);
      chk("arst_occ", i, 64'(occ_w[i]), 64'd0);
      chk("arst_bursts", i, 64'(bh_w[i]), 64'd0);
      chk("arst_rreadym", i, 64'(rdym_w[i]), 64'd0);
      mq[i].delete();
      msticky[i] = 1'b0;
      mrdy[i]    = 1'b0;
    end
    tick();
    areset = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < NI; i++) push_e[i] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (!(vm[i] && !push_e[i])) begin
          vm[i]       = ($urandom_range(0, 3) != 0);
          bin[i].id   = 4'($urandom);
          bin[i].data = $urandom;
          bin[i].resp = 4'($urandom);
          bin[i].last = ($urandom_range(0, 3) == 0);
          bin[i].user = 1'($urandom);
        end
        rs[i] = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      if (!(vm[i] && !push_e[i])) vm[i] = 1'b0;
      rs[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < NI; i++) vm[i] = vm[i] && !push_e[i];
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int i = 0; i < NI; i++) if (push_e[i]) vm[i] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
